cla_share_arbiter: RTL and testbench
====================================

Name: cla_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one combinational carry-lookahead adder core between two requesters.
- Each requester presents operands through a valid/ready handshake.
- The block grants one requester, registers its operands, and registers the sum and carry.
- The result is returned through a valid/ready response channel tagged with the requester ID.
- Sits between operand producers and the shared CLA datapath.

Parameters:
- WIDTH, 10, operand and sum width in bits; also the width of the adder core.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_z  out  WIDTH  sum, (a+b+cin) mod 2^WIDTH.
- rsp_cout  out  1  carry-out of the sum.
- rsp_id  out  1  requester that owns the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, prio=0, rsp_valid=0, rsp_z=0, rsp_cout=0, rsp_id=0, operand regs=0. Ready outputs are 0 while reset is asserted.
- States are IDLE, CALC and RESP.
- IDLE:
  - req*_ready is driven combinationally and only in IDLE.
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant prio.
  - The granted reqN_ready=1 in that same cycle. The non-granted ready=0.
  - On that edge, capture reqN_a/b/cin into op regs and N into the id reg, then go to CALC.
  - If no valid is high, stay in IDLE with both ready=0.
- CALC:
  - The adder core sees the op regs.
  - On the edge: rsp_z, rsp_cout <= core outputs; rsp_id <= id reg; rsp_valid <= 1; go to RESP.
  - Both ready outputs are 0.
- RESP:
  - rsp_valid=1; rsp_z, rsp_cout and rsp_id are held stable.
  - When rsp_valid & rsp_ready on an edge: rsp_valid <= 0, prio <= ~rsp_id, go to IDLE.
  - If rsp_ready stays low, hold indefinitely with outputs stable.
- Latency: 2 clock edges from acceptance to rsp_valid high. Minimum 3 cycles per operation when rsp_ready is tied high.
- prio changes only on response completion, so fairness is strictly alternating under continuous contention.
- The adder core is purely combinational; no arithmetic is done outside it. The carry-out is the natural bit WIDTH of the sum.
- Requester inputs are ignored outside IDLE. A requester must hold valid and operands until it sees ready.
- Reset asserted mid-operation (CALC or RESP) drops any in-flight result: rsp_valid goes to 0 immediately and the block returns to IDLE with prio=0.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - the default CLA operand width constant (10);
  - state encodings: IDLE=2'd0, CALC=2'd1, RESP=2'd2; 2'd3 is illegal and decodes to IDLE.
- One sub-module: cla_core, the combinational WIDTH-bit carry-lookahead adder (inputs a, b, cin; outputs z, cout), instantiated once.
- Arbitration and FSM stay in cla_share_arbiter.

Test Plan:
1. Single request: req0 a=10, b=6, cin=0, rsp_ready=1. Expect req0_ready pulse in the accept cycle, rsp_valid 2 edges later, z=16, cout=0, id=0.
2. Overflow: req1 a=530, b=520, cin=0 -> z=26, cout=1, id=1. Then a=1023, b=0, cin=1 -> z=0, cout=1.
3. Contention: req0 and req1 valid continuously from reset, with req0 (43, 22) and req1 (97, 143). Expect response order id 0,1,0,1 with z=65 and 240 alternating, and each ready pulse exactly once per response.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Expect rsp_valid, z and id stable, both ready outputs 0, and no new grant. Raise rsp_ready: expect completion, then IDLE the next cycle.
5. Reset mid-op: assert reset during CALC. Expect rsp_valid=0, busy=0 and prio=0 asynchronously. After release, a new req1 request is served normally.
6. Carry-in path: a=511, b=512, cin=1 -> z=0, cout=1. a=0, b=0, cin=1 -> z=1, cout=0.

Source files
------------

// File: rtl/cla_share_arbiter_pkg.sv
// Shared definitions for the two-requester CLA sharing arbiter:
// default operand width and FSM state encodings.
package cla_share_arbiter_pkg;

  localparam int CLA_WIDTH = 10;

  // 2'd3 is unused and is steered back to IDLE by the FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cla_share_arbiter_core.sv
// Purely combinational WIDTH-bit carry-lookahead adder shared by both requesters.
module cla_core
  import cla_share_arbiter_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each carry is the flat sum-of-products of generates and propagate chains
  always_comb begin
    logic carry_s;
    logic prod_s;
    c_s    = '0;
    c_s[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry_s = 1'b0;
      prod_s  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        carry_s = carry_s | (prod_s & g_s[j]);
        prod_s  = prod_s & p_s[j];
      end
      c_s[i+1] = carry_s | (prod_s & cin);
    end
  end

  assign z    = p_s ^ c_s[WIDTH-1:0];
  assign cout = c_s[WIDTH];

endmodule

// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter and sequencer time-sharing one CLA core between two
// valid/ready requesters, returning id-tagged results on a response channel.
module cla_share_arbiter
  import cla_share_arbiter_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  state_t           state_r, state_next_s;
  logic             prio_r, busy_r;
  logic [WIDTH-1:0] op_a_r, op_b_r;
  logic             op_cin_r, id_r;
  logic             rsp_valid_r, rsp_cout_r, rsp_id_r;
  logic [WIDTH-1:0] rsp_z_r;
  logic             accept_s, grant_s;
  logic [WIDTH-1:0] core_z_s;
  logic             core_cout_s;

  // Next-state, grant selection and combinational ready generation
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          accept_s = 1'b1;
          grant_s  = prio_r;
        end else if (req0_valid) begin
          accept_s = 1'b1;
          grant_s  = 1'b0;
        end else if (req1_valid) begin
          accept_s = 1'b1;
          grant_s  = 1'b1;
        end else begin
          accept_s = 1'b0;
          grant_s  = 1'b0;
        end
        if (accept_s) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: state_next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Readies are masked while reset is held so nothing looks accepted
  assign req0_ready = accept_s & ~grant_s & reset;
  assign req1_ready = accept_s &  grant_s & reset;

  // FSM state, busy flag and round-robin priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      prio_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (state_r == ST_RESP && rsp_ready) begin
        prio_r <= ~rsp_id_r;
      end
    end
  end

  // Operand capture from the granted requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_r   <= '0;
      op_b_r   <= '0;
      op_cin_r <= 1'b0;
      id_r     <= 1'b0;
    end else if (accept_s) begin
      op_a_r   <= grant_s ? req1_a   : req0_a;
      op_b_r   <= grant_s ? req1_b   : req0_b;
      op_cin_r <= grant_s ? req1_cin : req0_cin;
      id_r     <= grant_s;
    end
  end

  cla_core #(.WIDTH(WIDTH)) u_core (
    .a    (op_a_r),
    .b    (op_b_r),
    .cin  (op_cin_r),
    .z    (core_z_s),
    .cout (core_cout_s)
  );

  // Response registers: loaded in CALC, held through RESP until taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_z_r     <= '0;
      rsp_cout_r  <= 1'b0;
      rsp_id_r    <= 1'b0;
    end else if (state_r == ST_CALC) begin
      rsp_valid_r <= 1'b1;
      rsp_z_r     <= core_z_s;
      rsp_cout_r  <= core_cout_s;
      rsp_id_r    <= id_r;
    end else if (state_r == ST_RESP && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_z     = rsp_z_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Self-checking bench: directed and randomized operations against a
// behavioural model (integer sum, alternating priority, cycle timing).
module tb_cla_share_arbiter;

  localparam int W = 10;

  logic         clk, reset;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_z;

  int   tests  = 0;
  int   failed = 0;
  logic prio_m = 1'b0;

  cla_share_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set0(input int a, input int b, input int c);
    req0_valid = 1'b1; req0_a = W'(a); req0_b = W'(b); req0_cin = 1'(c);
  endtask

  task automatic set1(input int a, input int b, input int c);
    req1_valid = 1'b1; req1_a = W'(a); req1_b = W'(b); req1_cin = 1'(c);
  endtask

  // Entered shortly after a rising edge with the DUT idle; returns the same way.
  task automatic serve(input bit keep, input int bp);
    logic         g;
    int           sum;
    logic [W-1:0] ez;
    logic         ec;
    if (req0_valid && req1_valid) g = prio_m;
    else                          g = req1_valid;
    if (g) sum = int'(req1_a) + int'(req1_b) + int'(req1_cin);
    else   sum = int'(req0_a) + int'(req0_b) + int'(req0_cin);
    ez = W'(sum % (1 << W));
    ec = 1'(sum >> W);
    @(negedge clk);
    check("idle_busy",  32'(busy),       32'(0));
    check("idle_valid", 32'(rsp_valid),  32'(0));
    check("idle_rdy0",  32'(req0_ready), 32'(!g));
    check("idle_rdy1",  32'(req1_ready), 32'(g));
    @(posedge clk); #1;
    if (!keep) begin
      if (g) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
    end
    @(negedge clk);
    check("calc_busy",  32'(busy),       32'(1));
    check("calc_valid", 32'(rsp_valid),  32'(0));
    check("calc_rdy",   32'({req0_ready, req1_ready}), 32'(0));
    rsp_ready = (bp == 0);
    @(posedge clk); #1;
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      check("resp_valid", 32'(rsp_valid), 32'(1));
      check("resp_z",     32'(rsp_z),     32'(ez));
      check("resp_cout",  32'(rsp_cout),  32'(ec));
      check("resp_id",    32'(rsp_id),    32'(g));
      check("resp_rdy",   32'({req0_ready, req1_ready}), 32'(0));
      check("resp_busy",  32'(busy),      32'(1));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    prio_m = ~g;
  endtask

  task automatic reset_mid(input bit in_resp);
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    if (in_resp) begin
      @(posedge clk); #1;
      check("pre_rst_valid", 32'(rsp_valid), 32'(1));
    end
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy",  32'(busy),      32'(0));
    @(posedge clk); #1;
    reset = 1'b1; rsp_ready = 1'b1; prio_m = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    set0(43, 22, 0);
    set1(97, 143, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy0",  32'(req0_ready), 32'(0));
    check("rst_rdy1",  32'(req1_ready), 32'(0));
    check("rst_valid", 32'(rsp_valid),  32'(0));
    check("rst_busy",  32'(busy),       32'(0));
    check("rst_z",     32'(rsp_z),      32'(0));
    check("rst_cout",  32'(rsp_cout),   32'(0));
    check("rst_id",    32'(rsp_id),     32'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // Continuous contention: ids alternate 0,1,0,1 with sums 65/240
    for (int i = 0; i < 4; i++) serve(1'b1, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    set0(10, 6, 0);     serve(1'b0, 0);
    set1(530, 520, 0);  serve(1'b0, 0);
    set1(1023, 0, 1);   serve(1'b0, 0);
    set0(511, 512, 1);  serve(1'b0, 0);
    set1(0, 0, 1);      serve(1'b0, 0);

    // Backpressure while the other requester waits
    set0(300, 400, 1); set1(1000, 1000, 1);
    serve(1'b0, 5);
    serve(1'b0, 0);

    // Leave prio at 1, then reset mid-operation must restore prio 0
    set0(5, 5, 0);      serve(1'b0, 0);
    set0(1, 2, 0);      reset_mid(1'b0);
    set0(11, 22, 1); set1(33, 44, 0);
    serve(1'b0, 0);
    serve(1'b0, 0);
    set1(700, 300, 0);  serve(1'b0, 0);
    set0(5, 5, 0);      serve(1'b0, 0);
    set1(9, 9, 1);      reset_mid(1'b1);
    set1(100, 200, 1);  serve(1'b0, 1);

    for (int n = 0; n < 24; n++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1)
        set0(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
      if (!req1_valid && $urandom_range(0, 1) == 1)
        set1(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
      if (!req0_valid && !req1_valid)
        set0(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
      serve(1'b0, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
